// File: rtl/move_scheduler.sv
// Play-phase move scheduler: turns frame ticks, gravity and buttons into at most one
// horizontal and one vertical move command per frame, issued over a valid/ready handshake.
module move_scheduler #(
  parameter int unsigned GRAVITY_FRAMES = 48,
  parameter int unsigned GRAVITY_STEP   = 4,
  parameter int unsigned MIN_GRAVITY    = 4,
  parameter int unsigned REPEAT_DELAY   = 12,
  parameter int unsigned REPEAT_RATE    = 4
) (
  input  logic       vclk,
  input  logic       rst,
  input  logic       frame,
  input  logic       enable,
  input  logic       LEFT,
  input  logic       RIGHT,
  input  logic       DOWN,
  input  logic [3:0] level,
  output logic       cmd_valid,
  output logic [1:0] cmd_dir,
  input  logic       cmd_ready,
  input  logic       cmd_blocked,
  output logic       lock,
  output logic       overrun
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StIssueH = 2'd1;
  localparam logic [1:0] StIssueV = 2'd2;
  localparam logic [1:0] StLock   = 2'd3;

  localparam logic [1:0] DirLeft  = 2'b01;
  localparam logic [1:0] DirRight = 2'b10;
  localparam logic [1:0] DirDown  = 2'b11;

  localparam int unsigned RepMax = REPEAT_DELAY + REPEAT_RATE;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  logic [1:0]      state_q, state_d;
  logic [9:0]      grav_cnt_q, grav_cnt_d;
  logic            grav_pend_q, grav_pend_d;
  logic [RepW-1:0] rep_cnt_q, rep_cnt_d, rep_nx;
  logic            prev_l_q, prev_l_d, prev_r_q, prev_r_d;
  logic            h_pend_q, h_pend_d;
  logic [1:0]      h_dir_q, h_dir_d;
  logic            v_pend_q, v_pend_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [1:0]      cmd_dir_q, cmd_dir_d;
  logic            overrun_q, overrun_d;

  logic signed [9:0] period_raw;
  logic [9:0]        period;
  logic              frame_en, grav_fire;
  logic              h_req;
  logic [1:0]        h_req_dir;

  // Period may go negative at high levels, hence the signed clamp.
  assign period_raw = $signed(10'(GRAVITY_FRAMES)) - $signed(10'(level) * 10'(GRAVITY_STEP));
  assign period     = (period_raw < $signed(10'(MIN_GRAVITY))) ? 10'(MIN_GRAVITY)
                                                               : $unsigned(period_raw);

  assign frame_en  = frame & enable;
  assign grav_fire = frame_en && (grav_cnt_q >= (period - 10'd1));

  // Horizontal press / auto-repeat detection; history updates on every enabled frame.
  always_comb begin
    h_req     = 1'b0;
    h_req_dir = DirLeft;
    rep_cnt_d = rep_cnt_q;
    prev_l_d  = prev_l_q;
    prev_r_d  = prev_r_q;
    rep_nx    = (rep_cnt_q == RepW'(RepMax)) ? RepW'(REPEAT_DELAY + 1) : rep_cnt_q + RepW'(1);
    if (!enable) begin
      rep_cnt_d = '0;
      prev_l_d  = 1'b0;
      prev_r_d  = 1'b0;
    end else if (frame) begin
      prev_l_d = LEFT;
      prev_r_d = RIGHT;
      if (LEFT ^ RIGHT) begin
        h_req_dir = LEFT ? DirLeft : DirRight;
        if ((LEFT && !prev_l_q) || (RIGHT && !prev_r_q)) begin
          h_req     = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_nx;
          h_req     = (rep_nx == RepW'(REPEAT_DELAY)) || (rep_nx == RepW'(RepMax));
        end
      end else begin
        rep_cnt_d = '0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grav_cnt_d  = grav_cnt_q;
    grav_pend_d = grav_pend_q;
    h_pend_d    = h_pend_q;
    h_dir_d     = h_dir_q;
    v_pend_d    = v_pend_q;
    cmd_valid_d = 1'b0;
    cmd_dir_d   = 2'b00;
    overrun_d   = frame && (state_q != StIdle);

    // Gravity keeps running outside IDLE; grav_pend stays sticky until served.
    if (frame_en) begin
      if (grav_fire) begin
        grav_cnt_d  = '0;
        grav_pend_d = 1'b1;
      end else begin
        grav_cnt_d = grav_cnt_q + 10'd1;
      end
    end

    case (state_q)
      StIdle: begin
        if (frame_en) begin
          h_pend_d    = h_req;
          h_dir_d     = h_req_dir;
          v_pend_d    = DOWN | grav_pend_q | grav_fire;
          grav_pend_d = 1'b0;
          if (DOWN) grav_cnt_d = '0;
          if (h_req) begin
            state_d     = StIssueH;
            cmd_valid_d = 1'b1;
            cmd_dir_d   = h_req_dir;
          end else if (v_pend_d) begin
            state_d     = StIssueV;
            cmd_valid_d = 1'b1;
            cmd_dir_d   = DirDown;
          end
        end
      end
      StIssueH: begin
        cmd_valid_d = 1'b1;
        cmd_dir_d   = h_dir_q;
        if (cmd_ready) begin
          h_pend_d = 1'b0;
          if (v_pend_q && enable) begin
            state_d   = StIssueV;
            cmd_dir_d = DirDown;
          end else begin
            state_d     = StIdle;
            cmd_valid_d = 1'b0;
            cmd_dir_d   = 2'b00;
          end
        end
      end
      StIssueV: begin
        cmd_valid_d = 1'b1;
        cmd_dir_d   = DirDown;
        if (cmd_ready) begin
          v_pend_d    = 1'b0;
          cmd_valid_d = 1'b0;
          cmd_dir_d   = 2'b00;
          state_d     = cmd_blocked ? StLock : StIdle;
        end
      end
      StLock: begin
        h_pend_d    = 1'b0;
        v_pend_d    = 1'b0;
        grav_pend_d = 1'b0;
        grav_cnt_d  = '0;
        state_d     = StIdle;
      end
    endcase

    // Leaving Play: an in-flight command still completes before pending work is dropped.
    if (!enable) begin
      grav_cnt_d  = '0;
      grav_pend_d = 1'b0;
      if (state_d == StIdle) begin
        h_pend_d = 1'b0;
        v_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      grav_cnt_q  <= '0;
      grav_pend_q <= 1'b0;
      rep_cnt_q   <= '0;
      prev_l_q    <= 1'b0;
      prev_r_q    <= 1'b0;
      h_pend_q    <= 1'b0;
      h_dir_q     <= 2'b00;
      v_pend_q    <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_dir_q   <= 2'b00;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grav_cnt_q  <= grav_cnt_d;
      grav_pend_q <= grav_pend_d;
      rep_cnt_q   <= rep_cnt_d;
      prev_l_q    <= prev_l_d;
      prev_r_q    <= prev_r_d;
      h_pend_q    <= h_pend_d;
      h_dir_q     <= h_dir_d;
      v_pend_q    <= v_pend_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_dir_q   <= cmd_dir_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_dir   = cmd_dir_q;
  assign lock      = (state_q == StLock);
  assign overrun   = overrun_q;

  // Handshake invariants relied on by the movement datapath.
  assert property (@(posedge vclk) disable iff (rst)
    cmd_valid && !cmd_ready |=> cmd_valid && $stable(cmd_dir));
  assert property (@(posedge vclk) disable iff (rst) cmd_valid |-> cmd_dir != 2'b00);
  assert property (@(posedge vclk) disable iff (rst) lock |=> !lock);

endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler: constant-input vector table, hand-built handshake/lock
// sequences, and randomized buttons checked against a frame-level reference model.
module tb_move_scheduler;
  localparam int GF = 48;
  localparam int GS = 4;
  localparam int MG = 4;
  localparam int RD = 12;
  localparam int RR = 4;
  localparam int Gap = 16;

  logic       vclk = 1'b0;
  logic       rst, frame, enable, LEFT, RIGHT, DOWN;
  logic [3:0] level;
  logic       cmd_valid, cmd_ready, cmd_blocked, lock, overrun;
  logic [1:0] cmd_dir;

  move_scheduler #(
    .GRAVITY_FRAMES(GF), .GRAVITY_STEP(GS), .MIN_GRAVITY(MG),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .vclk(vclk), .rst(rst), .frame(frame), .enable(enable),
    .LEFT(LEFT), .RIGHT(RIGHT), .DOWN(DOWN), .level(level),
    .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .cmd_ready(cmd_ready),
    .cmd_blocked(cmd_blocked), .lock(lock), .overrun(overrun)
  );

  always #5 vclk = ~vclk;

  int checks = 0;
  int failures = 0;
  int frame_no = 0;
  int lock_cnt = 0;
  int ovr_cnt = 0;
  logic [1:0] obs_dir[$];
  int obs_frm[$];
  int fix_dly = 0;
  bit rnd_dly = 0;
  int blk_mode = 0;
  bit blk_frame = 0;

  typedef struct {
    logic [3:0] lvl;
    logic l, r, d;
    int nfr, exp_h, exp_v, first_h, first_v;
  } vec_t;
  vec_t vt[9];
  int lf[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pick_dly();
    return rnd_dly ? int'($urandom_range(0, 3)) : fix_dly;
  endfunction

  function automatic logic [1:0] odir(input int j);
    return (j < obs_dir.size()) ? obs_dir[j] : 2'b00;
  endfunction

  function automatic int ofrm(input int j);
    return (j < obs_frm.size()) ? obs_frm[j] : -1;
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge vclk);
      #1;
    end
  endtask

  task automatic pulse_frame(input int gap);
    frame = 1'b1;
    frame_no++;
    cycles(1);
    frame = 1'b0;
    cycles(gap - 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame = 1'b0; enable = 1'b0; LEFT = 1'b0; RIGHT = 1'b0; DOWN = 1'b0;
    cycles(2);
    obs_dir.delete(); obs_frm.delete();
    lock_cnt = 0; ovr_cnt = 0; frame_no = 0;
    rst = 1'b0;
    cycles(1);
  endtask

  // Ready/blocked responder: stalls each command by a chosen number of cycles.
  initial begin : responder
    int stall;
    stall = 0;
    cmd_ready = 1'b0;
    cmd_blocked = 1'b0;
    forever begin
      @(posedge vclk);
      #1;
      if (rst !== 1'b0) begin
        cmd_ready = 1'b0; cmd_blocked = 1'b0; stall = pick_dly();
      end else begin
        if (cmd_ready) stall = pick_dly();
        if (cmd_valid && stall == 0) begin
          cmd_ready = 1'b1;
          cmd_blocked = (cmd_dir == 2'b11) &&
                        ((blk_mode == 1) || (blk_mode == 2 && blk_frame));
        end else begin
          cmd_ready = 1'b0;
          cmd_blocked = 1'b0;
          if (cmd_valid) stall--;
        end
      end
    end
  end

  // Transfer log plus handshake-stability and pulse-width checks.
  initial begin : monitor
    logic pv, pr, plk, pov;
    logic [1:0] pd;
    pv = 0; pr = 0; plk = 0; pov = 0; pd = 0;
    forever begin
      @(negedge vclk);
      if (rst !== 1'b0) begin
        pv = 0; pr = 0; plk = 0; pov = 0;
      end else begin
        if (pv && !pr) begin
          check("hold_valid", cmd_valid, 1);
          check("hold_dir", cmd_dir, pd);
        end
        if (cmd_valid && cmd_ready) begin
          obs_dir.push_back(cmd_dir);
          obs_frm.push_back(frame_no);
        end
        if (lock) begin lock_cnt++; check("lock_width", plk, 0); end
        if (overrun) begin ovr_cnt++; check("overrun_width", pov, 0); end
        pv = cmd_valid; pr = cmd_ready; pd = cmd_dir; plk = lock; pov = overrun;
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    int nh, nv, fh, fv, k, g, p, exp_lock;
    bit pl, prr, bl, br, bd, hreq, fire;
    logic [1:0] exp_d[$];
    int exp_f[$];

    //        lvl    L     R     D   frames H  V  1stH 1stV
    vt[0] = '{4'd0,  1'b0, 1'b0, 1'b0, 48, 0, 1,  0, 48};
    vt[1] = '{4'd15, 1'b0, 1'b0, 1'b0, 48, 0, 12, 0, 4};
    vt[2] = '{4'd5,  1'b0, 1'b0, 1'b0, 56, 0, 2,  0, 28};
    vt[3] = '{4'd0,  1'b1, 1'b0, 1'b0, 30, 6, 0,  1, 0};
    vt[4] = '{4'd0,  1'b1, 1'b1, 1'b0, 48, 0, 1,  0, 48};
    vt[5] = '{4'd0,  1'b0, 1'b1, 1'b0, 12, 1, 0,  1, 0};
    vt[6] = '{4'd12, 1'b0, 1'b0, 1'b0, 8,  0, 2,  0, 4};
    vt[7] = '{4'd0,  1'b0, 1'b0, 1'b1, 5,  0, 5,  0, 1};
    vt[8] = '{4'd10, 1'b0, 1'b1, 1'b0, 24, 4, 3,  1, 8};
    lf = '{1, 13, 17, 21, 25, 29};

    rst = 1'b1; frame = 0; enable = 0; LEFT = 0; RIGHT = 0; DOWN = 0; level = 0;
    cycles(3);
    check("rst_valid", cmd_valid, 0);
    check("rst_dir", cmd_dir, 0);
    check("rst_lock", lock, 0);
    check("rst_overrun", overrun, 0);

    for (int i = 0; i < 9; i++) begin
      do_reset();
      fix_dly = 0; rnd_dly = 0; blk_mode = 0;
      level = vt[i].lvl; LEFT = vt[i].l; RIGHT = vt[i].r; DOWN = vt[i].d; enable = 1'b1;
      repeat (vt[i].nfr) pulse_frame(Gap);
      cycles(20);
      nh = 0; nv = 0; fh = 0; fv = 0;
      foreach (obs_dir[j]) begin
        if (obs_dir[j] == 2'b11) begin nv++; if (fv == 0) fv = obs_frm[j]; end
        else begin nh++; if (fh == 0) fh = obs_frm[j]; end
      end
      check("vec_h_count", nh, vt[i].exp_h);
      check("vec_v_count", nv, vt[i].exp_v);
      check("vec_first_h", fh, vt[i].first_h);
      check("vec_first_v", fv, vt[i].first_v);
      check("vec_drained", cmd_valid, 0);
      if (i == 3) begin
        for (int j = 0; j < 6; j++) begin
          check("left_dir", odir(j), 2'b01);
          check("left_frame", ofrm(j), lf[j]);
        end
      end
    end

    // RIGHT and DOWN on one frame with 3-cycle stalls: H before V, payload held.
    do_reset();
    fix_dly = 3; rnd_dly = 0; blk_mode = 0; level = 0; enable = 1'b1;
    RIGHT = 1'b1; DOWN = 1'b1;
    pulse_frame(Gap);
    RIGHT = 1'b0; DOWN = 1'b0;
    cycles(10);
    check("hv_count", obs_dir.size(), 2);
    check("hv_first_right", odir(0), 2'b10);
    check("hv_second_down", odir(1), 2'b11);

    // Asynchronous reset while a command is stalled.
    do_reset();
    fix_dly = 6; level = 0; enable = 1'b1; DOWN = 1'b1;
    pulse_frame(3);
    check("stalled_valid", cmd_valid, 1);
    #2 rst = 1'b1;
    #1 check("async_rst_valid", cmd_valid, 0);
    check("async_rst_dir", cmd_dir, 0);

    // Blocked down move: overrun during stall, single lock pulse, gravity restarts.
    do_reset();
    fix_dly = 6; blk_mode = 1; level = 0; enable = 1'b1; DOWN = 1'b1;
    pulse_frame(3);
    DOWN = 1'b0;
    pulse_frame(12);
    check("lock_count", lock_cnt, 1);
    check("overrun_count", ovr_cnt, 1);
    check("post_lock_idle", cmd_valid, 0);
    blk_mode = 0;
    repeat (48) pulse_frame(Gap);
    cycles(20);
    check("lock_total", lock_cnt, 1);
    check("relock_count", obs_dir.size(), 2);
    check("regrav_dir", odir(1), 2'b11);
    check("regrav_frame", ofrm(1), 50);

    // Randomized buttons and stalls against the frame-level model.
    for (int s = 0; s < 4; s++) begin
      do_reset();
      rnd_dly = 1; blk_mode = 2; enable = 1'b1;
      level = 4'($urandom_range(0, 15));
      p = GF - int'(level) * GS;
      if (p < MG) p = MG;
      k = 0; g = 0; pl = 0; prr = 0; bl = 0; br = 0; exp_lock = 0;
      exp_d.delete(); exp_f.delete();
      for (int f = 1; f <= 60; f++) begin
        if ($urandom_range(0, 5) == 0) begin
          bl = 1'($urandom_range(0, 1));
          br = 1'($urandom_range(0, 1));
        end
        bd = ($urandom_range(0, 7) == 0);
        blk_frame = 1'($urandom_range(0, 1));
        hreq = 0;
        if (bl != br) begin
          if ((bl && !pl) || (br && !prr)) begin k = 0; hreq = 1; end
          else begin k++; hreq = (k >= RD) && ((k - RD) % RR == 0); end
        end else k = 0;
        pl = bl; prr = br;
        g++;
        fire = (g >= p);
        if (fire || bd) g = 0;
        if (hreq) begin exp_d.push_back(br ? 2'b10 : 2'b01); exp_f.push_back(f); end
        if (bd || fire) begin
          exp_d.push_back(2'b11); exp_f.push_back(f);
          if (blk_frame) begin exp_lock++; g = 0; end
        end
        LEFT = bl; RIGHT = br; DOWN = bd;
        pulse_frame(Gap);
      end
      cycles(20);
      check("rnd_count", obs_dir.size(), exp_d.size());
      for (int j = 0; j < exp_d.size(); j++) begin
        check("rnd_dir", odir(j), exp_d[j]);
        check("rnd_frame", ofrm(j), exp_f[j]);
      end
      check("rnd_locks", lock_cnt, exp_lock);
      check("rnd_overruns", ovr_cnt, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
- Sequences all piece movement for the Play phase of the game FSM.
- Converts frame ticks, a level-dependent gravity timer and the LEFT/RIGHT/DOWN buttons into at most one horizontal and one vertical move command per video frame.
- Hands each command to the block-movement datapath over a valid/ready handshake.
- Raises a one-cycle lock pulse when a downward move is blocked, which ends the piece's fall.

Parameters:
- GRAVITY_FRAMES, 48: gravity period in frames at level 0.
- GRAVITY_STEP, 4: frames removed from the period per level.
- MIN_GRAVITY, 4: lower clamp on the gravity period.
- REPEAT_DELAY, 12: frames a horizontal button is held before auto-repeat starts.
- REPEAT_RATE, 4: frames between auto-repeat moves.

Ports:
- vclk  in  1  pixel/system clock.
- rst  in  1  reset, asynchronous, active-high.
- frame  in  1  one-vclk pulse per video frame.
- enable  in  1  high while the game FSM is in Play.
- LEFT  in  1  debounced, synchronised button level.
- RIGHT  in  1  debounced, synchronised button level.
- DOWN  in  1  debounced, synchronised button level.
- level  in  4  current game level, 0..15.
- cmd_valid  out  1  move command valid.
- cmd_dir  out  2  01 = left, 10 = right, 11 = down; 00 only when cmd_valid=0.
- cmd_ready  in  1  movement datapath accepts the command this cycle.
- cmd_blocked  in  1  qualified by cmd_ready: the move collided and was not applied.
- lock  out  1  one-cycle pulse when a down move is blocked.
- overrun  out  1  one-cycle pulse when a frame arrives while the FSM is not IDLE.

Behaviour:
- Reset (async): state IDLE; all counters and pending flags 0; cmd_valid=0, cmd_dir=00, lock=0, overrun=0.
- Gravity period:
  - P = GRAVITY_FRAMES − level×GRAVITY_STEP, computed in 10 bits signed.
  - If P < MIN_GRAVITY, use P = MIN_GRAVITY.
- Gravity counter:
  - Increments on each frame while enable=1.
  - On reaching P−1 it sets grav_pend and clears to 0.
  - Cleared whenever a soft-drop request is latched.
  - Cleared when enable=0.
- Horizontal request, evaluated on each frame while enable=1:
  - Exactly one of LEFT/RIGHT is high, and it was low on the previous frame: request that direction and clear rep_cnt.
  - The same button is still held: increment rep_cnt, saturating at REPEAT_DELAY+REPEAT_RATE.
    - Request when rep_cnt reaches REPEAT_DELAY.
    - After that, request every REPEAT_RATE frames.
  - Both high or both low: no request and rep_cnt=0.
  - Direction change (L to R) counts as a new press.
- Vertical request: on a frame, DOWN=1 or grav_pend=1 sets v_pend. grav_pend clears when v_pend is latched.
- FSM states and transitions:
  - IDLE: on a frame with enable=1, latch h_pend/h_dir and v_pend.
    - If h_pend, go to ISSUE_H; else if v_pend, go to ISSUE_V; else stay.
  - ISSUE_H: cmd_valid=1, cmd_dir=h_dir.
    - On cmd_ready, clear h_pend.
    - Go to ISSUE_V if v_pend, else IDLE.
    - A blocked horizontal move is simply dropped.
  - ISSUE_V: cmd_valid=1, cmd_dir=11.
    - On cmd_ready with cmd_blocked=1, go to LOCK.
    - On cmd_ready with cmd_blocked=0, go to IDLE.
  - LOCK: lock=1 for exactly one cycle; clear all pending flags and the gravity counter; go to IDLE.
- Handshake rules:
  - cmd_valid and cmd_dir are registered outputs.
  - Once cmd_valid is asserted, it and cmd_dir are held stable until the cycle cmd_ready=1.
  - Transfer occurs in the cycle where cmd_valid and cmd_ready are both high.
  - Minimum 1 cycle per command; the next command's cmd_valid may assert in the cycle after acceptance.
- Frame while not IDLE:
  - overrun pulses.
  - The gravity counter still advances and grav_pend is sticky, so it is served next frame.
  - Button requests for that frame are discarded, but rep_cnt and previous-button history still update.
- enable falling mid-command: the outstanding command completes its handshake (valid is never withdrawn), then the FSM goes to IDLE and pending flags clear. No lock is issued unless that final down move was blocked.
- Reset mid-handshake: cmd_valid drops immediately (async). The datapath must tolerate this.
- frame coincident with LOCK: overrun pulses and the frame is not latched.

Test Plan:
- Reset, then enable=1, level=0, no buttons for 48 frames → exactly one down command issued after the 48th frame; cmd_dir=11; no others.
- level=15 → gravity period clamps to 4: a down command every 4 frames. level=5 → every 28 frames.
- LEFT held 30 frames, cmd_ready tied 1, cmd_blocked=0 → left commands at frames 1, 13, 17, 21, 25, 29 (press frame = 1).
- LEFT and RIGHT both held → no horizontal commands; gravity commands continue unaffected.
- DOWN and RIGHT pressed on the same frame, cmd_ready delayed 3 cycles each → right command held stable, then down command; ordering H before V; payloads unchanged while stalled.
- Down command answered with cmd_ready=1, cmd_blocked=1 → lock high for exactly 1 cycle, FSM in IDLE next cycle, gravity restarts from 0. Also pulse frame during ISSUE_V stall → overrun=1 for 1 cycle.
